// File: rtl/counter_pkg.sv
// Shared definitions for the synchronous modulo-N counter family.
package counter_pkg;

    localparam int unsigned RADIX_MAX  = 16;
    localparam int unsigned DIGITS_MAX = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    // Bits needed to hold one digit of the given radix (never less than one).
    function automatic int unsigned digit_width(input int unsigned radix);
        return (radix <= 2) ? 1 : $clog2(radix);
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-RADIX digit: clear, sanitised parallel load, and up/down step
// gated by the shared enable and the prefix carry from lower digits.
module mod_n_digit
    import counter_pkg::*;
#(
    parameter  int unsigned RADIX = 10,
    localparam int unsigned W     = digit_width(RADIX)
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic         carry_in,
    input  logic         up_down,
    output logic [W-1:0] q,
    output logic         at_max,
    output logic         at_zero
);

    localparam logic [W-1:0] MAX_V = W'(RADIX - 1);
    localparam logic [W-1:0] ONE   = W'(1);

    // Boundary flags feed the top-level carry/borrow prefix.
    always_comb begin
        at_max  = (q == MAX_V);
        at_zero = (q == '0);
    end

    // Digit register: clear > load > count > hold; out-of-range loads become 0.
    always_ff @(posedge clock) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= (load_value > MAX_V) ? '0 : load_value;
        end else if (enable && carry_in) begin
            if (count_dir_e'(up_down) == DIR_UP) begin
                q <= at_max ? '0 : q + ONE;
            end else begin
                q <= at_zero ? MAX_V : q - ONE;
            end
        end
    end

endmodule

// File: rtl/cascaded_mod_n_counter.sv
// Fully synchronous multi-digit modulo-RADIX counter with up/down, load,
// enable and a cascadable terminal-count output.
module cascaded_mod_n_counter
    import counter_pkg::*;
#(
    parameter  int unsigned RADIX  = 10,
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned W      = digit_width(RADIX)
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                enable,
    input  logic                up_down,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_value,
    output logic [DIGITS*W-1:0] q,
    output logic                terminal,
    output logic                carry_out
);

    count_dir_e        dir;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] match;
    logic [DIGITS-1:0] carry;
    logic              all_match;

    assign dir = count_dir_e'(up_down);

    // Per-digit "at boundary for the current direction" flags.
    always_comb begin
        match = (dir == DIR_UP) ? at_max : at_zero;
    end

    // Carry/borrow AND-prefix, built with a local accumulator so the chain
    // has no combinational self-dependency on a shared vector.
    always_comb begin
        logic acc;
        acc   = 1'b1;
        carry = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            carry[i] = acc;
            acc      = acc & match[i];
        end
        all_match = acc;
    end

    // Terminal count and the qualified cascade output.
    always_comb begin
        terminal  = all_match;
        carry_out = all_match & enable & ~load & ~clear;
    end

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_digit
        mod_n_digit #(
            .RADIX (RADIX)
        ) u_digit (
            .clock      (clock),
            .clear      (clear),
            .load       (load),
            .load_value (load_value[g*W +: W]),
            .enable     (enable),
            .carry_in   (carry[g]),
            .up_down    (up_down),
            .q          (q[g*W +: W]),
            .at_max     (at_max[g]),
            .at_zero    (at_zero[g])
        );
    end

endmodule
